// File: rtl/dmem_mio_responder_pkg.sv
// Shared encodings for the data-memory/MIO responder: Dm_ctrl access codes, MMIO word offsets
// and access-size decoding helpers.
package dmem_mio_responder_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_BYTE   = 3'b001;
  localparam logic [2:0] DM_HALF   = 3'b010;
  localparam logic [2:0] DM_BYTE_U = 3'b011;
  localparam logic [2:0] DM_HALF_U = 3'b100;

  // Word offsets (byte offset >> 2) inside the MMIO window
  localparam logic [25:0] MMIO_LED_WORD = 26'd0;
  localparam logic [25:0] MMIO_SW_WORD  = 26'd1;
  localparam logic [25:0] MMIO_CNT_WORD = 26'd2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Codes 101..111 fall through to word access
  function automatic acc_size_e dm_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_BYTE, DM_BYTE_U: return SZ_BYTE;
      DM_HALF, DM_HALF_U: return SZ_HALF;
      default:            return SZ_WORD;
    endcase
  endfunction

  function automatic logic dm_unsigned(input logic [2:0] ctrl);
    return (ctrl == DM_BYTE_U) || (ctrl == DM_HALF_U);
  endfunction

endpackage

// File: rtl/dmem_mio_responder_lane.sv
// Byte-lane steering: store byte-enables/data replication and load lane extraction with
// sign/zero extension. Sub-word accesses are forced onto their natural alignment.
module dmem_lane
  import dmem_mio_responder_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_ctrl,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wrep,
  output logic [31:0] o_rdata
);

  acc_size_e   w_size;
  logic [1:0]  w_off;
  logic [31:0] w_shifted;
  logic        w_uns;

  assign w_size    = dm_size(i_ctrl);
  assign w_uns     = dm_unsigned(i_ctrl);
  assign w_off     = (w_size == SZ_BYTE) ? i_addr_lo :
                     (w_size == SZ_HALF) ? {i_addr_lo[1], 1'b0} : 2'b00;
  assign w_shifted = i_rword >> {w_off, 3'b000};

  always_comb begin
    o_be    = 4'b1111;
    o_wrep  = i_wdata;
    o_rdata = i_rword;
    case (w_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << w_off;
        o_wrep  = {4{i_wdata[7:0]}};
        o_rdata = w_uns ? {24'b0, w_shifted[7:0]} : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        o_be    = w_off[1] ? 4'b1100 : 4'b0011;
        o_wrep  = {2{i_wdata[15:0]}};
        o_rdata = w_uns ? {16'b0, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_mio_responder.sv
// CPU data-memory/MIO responder: word RAM, LED/switch/cycle-counter MMIO, optional wait states.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned W/H accesses via mem_err instead of aligning them.
module dmem_mio_responder
  import dmem_mio_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hF000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] Addr_out,
  input  logic [31:0] Data_out,
  input  logic [2:0]  Dm_ctrl,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  output logic        mem_err,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [31:0]   w_addr, w_wdata, w_rword, w_load, w_wrep;
  logic [2:0]    w_ctrl;
  logic          w_we, w_commit, w_err, w_is_mmio;
  logic [3:0]    w_be;
  logic [25:0]   w_mmio_word;
  logic [AW-1:0] w_ram_idx;

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [15:0]   r_led;
  logic [31:0]   r_cnt;

  assign w_is_mmio   = (w_addr[31:28] == MMIO_BASE[31:28]);
  assign w_mmio_word = w_addr[27:2];
  // Upper RAM address bits are ignored, so the array aliases across the address space
  assign w_ram_idx   = w_addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_err = ((dm_size(w_ctrl) == SZ_WORD) && (w_addr[1:0] != 2'b00)) ||
                 ((dm_size(w_ctrl) == SZ_HALF) && w_addr[0]);
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_rword = r_mem[w_ram_idx];
    if (w_is_mmio) begin
      case (w_mmio_word)
        MMIO_LED_WORD: w_rword = {16'b0, r_led};
        MMIO_SW_WORD:  w_rword = {16'b0, sw_in};
        MMIO_CNT_WORD: w_rword = r_cnt;
        default:       w_rword = 32'b0;
      endcase
    end
  end

  dmem_lane u_lane (
    .i_addr_lo (w_addr[1:0]),
    .i_ctrl    (w_ctrl),
    .i_wdata   (w_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wrep    (w_wrep),
    .o_rdata   (w_load)
  );

  always_ff @(posedge clk) begin
    if (w_commit && !w_is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_ram_idx][8*b +: 8] <= w_wrep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_led <= 16'b0;
      r_cnt <= 32'b0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      if (w_commit && w_is_mmio && (w_mmio_word == MMIO_LED_WORD)) begin
        if (w_be[0]) r_led[7:0]  <= w_wrep[7:0];
        if (w_be[1]) r_led[15:8] <= w_wrep[15:8];
      end
    end
  end

  assign led_out = r_led;

  generate
    if (WAIT_STATES == 0) begin : g_comb
      assign w_addr    = Addr_out;
      assign w_wdata   = Data_out;
      assign w_ctrl    = Dm_ctrl;
      assign w_we      = mem_w;
      assign w_commit  = CPU_MIO && w_we && !w_err;
      assign MIO_ready = CPU_MIO;
      assign mem_err   = CPU_MIO && w_err;
      assign Data_in   = (CPU_MIO && !w_we && !w_err) ? w_load : 32'b0;
    end else begin : g_fsm
      logic [1:0]  r_state;
      logic [2:0]  r_wcnt;
      logic [31:0] r_addr, r_wdata, r_dout;
      logic [2:0]  r_ctrl;
      logic        r_we, r_err, w_last;

      assign w_addr   = r_addr;
      assign w_wdata  = r_wdata;
      assign w_ctrl   = r_ctrl;
      assign w_we     = r_we;
      assign w_last   = (r_state == S_WAIT) && (r_wcnt == 3'd0);
      // The store lands on the same edge that enters RESP
      assign w_commit = w_last && w_we && !w_err;

      always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && CPU_MIO) begin
          r_addr  <= Addr_out;
          r_wdata <= Data_out;
          r_ctrl  <= Dm_ctrl;
          r_we    <= mem_w;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= S_IDLE;
          r_wcnt  <= 3'd0;
          r_dout  <= 32'b0;
          r_err   <= 1'b0;
        end else begin
          case (r_state)
            S_IDLE: if (CPU_MIO) begin
              r_state <= S_WAIT;
              r_wcnt  <= 3'(WAIT_STATES - 1);
            end
            S_WAIT: if (w_last) begin
              r_state <= S_RESP;
              r_err   <= w_err;
              if (!w_we || w_err) r_dout <= w_err ? 32'b0 : w_load;
            end else begin
              r_wcnt <= r_wcnt - 3'd1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end

      assign MIO_ready = (r_state == S_RESP);
      assign mem_err   = (r_state == S_RESP) && r_err;
      assign Data_in   = r_dout;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_mio_responder.sv
// Bench for dmem_mio_responder: a zero-wait and a three-wait-state instance checked against
// a byte-addressed reference memory plus directed MMIO, reset and alignment cases.
module tb_dmem_mio_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n0, cpu0, we0, rdy0, err0;
  logic [31:0] addr0, wd0, din0;
  logic [2:0]  ctl0;
  logic [15:0] sw0, led0;

  logic        rst_n3, cpu3, we3, rdy3, err3;
  logic [31:0] addr3, wd3, din3;
  logic [2:0]  ctl3;
  logic [15:0] sw3, led3;

  dmem_mio_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .MMIO_BASE(32'hF000_0000)) u_dut0 (
    .clk(clk), .reset_n(rst_n0), .CPU_MIO(cpu0), .mem_w(we0), .Addr_out(addr0),
    .Data_out(wd0), .Dm_ctrl(ctl0), .Data_in(din0), .MIO_ready(rdy0), .mem_err(err0),
    .sw_in(sw0), .led_out(led0));

  dmem_mio_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3), .MMIO_BASE(32'hF000_0000)) u_dut3 (
    .clk(clk), .reset_n(rst_n3), .CPU_MIO(cpu3), .mem_w(we3), .Addr_out(addr3),
    .Data_out(wd3), .Dm_ctrl(ctl3), .Data_in(din3), .MIO_ready(rdy3), .mem_err(err3),
    .sw_in(sw3), .led_out(led3));

  int n_checks = 0;
  int n_err = 0;
  logic [7:0] mb [2][4096];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: little-endian byte memory, 4 KiB image shared by all aliases
  function automatic int sz(input logic [2:0] c);
    if (c == 3'd1 || c == 3'd3) return 1;
    if (c == 3'd2 || c == 3'd4) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [31:0] a, input logic [2:0] c);
`ifdef DMEM_MISALIGN_TRAP_EN
    return (int'(a[1:0]) % sz(c)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_base(input logic [31:0] a, input logic [2:0] c);
    int b;
    b = int'(a[11:0]);
    return b - (b % sz(c));
  endfunction

  function automatic void m_store(input int d, input logic [31:0] a, input logic [31:0] v, input logic [2:0] c);
    if (m_mis(a, c)) return;
    for (int i = 0; i < sz(c); i++) mb[d][m_base(a, c) + i] = v[8*i +: 8];
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [31:0] a, input logic [2:0] c);
    logic [31:0] v, mask;
    int n;
    if (m_mis(a, c)) return 32'b0;
    n = sz(c);
    v = 32'b0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][m_base(a, c) + i];
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*n)) - 32'd1);
    if ((c == 3'd1 || c == 3'd2) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic req0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                      output logic [31:0] rd, output logic rdy, output logic er);
    @(negedge clk);
    cpu0 = 1'b1; we0 = w; addr0 = a; wd0 = d; ctl0 = c;
    #1;
    rd = din0; rdy = rdy0; er = err0;
    if (w && a[31:28] != 4'hF) m_store(0, a, d, c);
  endtask

  task automatic st0(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    logic [31:0] rd;
    logic rdy, er;
    req0(1'b1, a, d, c, rd, rdy, er);
  endtask

  task automatic ld0(input string tag, input logic [31:0] a, input logic [2:0] c, input logic [31:0] exp);
    logic [31:0] rd;
    logic rdy, er;
    req0(1'b0, a, 32'b0, c, rd, rdy, er);
    chk(tag, rd, exp);
  endtask

  task automatic req3(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c,
                      output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    cpu3 = 1'b1; we3 = w; addr3 = a; wd3 = d; ctl3 = c;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!rdy3 && lat < 16);
    rd = din3; er = err3;
    if (w && a[31:28] != 4'hF && rdy3) m_store(1, a, d, c);
    @(negedge clk);
    cpu3 = 1'b0;
    @(posedge clk); #1;
    chk("ws3_latency", 32'(lat), 32'd4);
    chk("ws3_ready_width", 32'(rdy3), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a, d;
    logic        rdy, er, w;
    logic [2:0]  c;
    int          pulses;

    for (int k = 0; k < 4096; k++) begin mb[0][k] = 8'h00; mb[1][k] = 8'h00; end
    rst_n0 = 1'b0; cpu0 = 1'b0; we0 = 1'b0; addr0 = 32'b0; wd0 = 32'b0; ctl0 = 3'd0; sw0 = 16'hC3C3;
    rst_n3 = 1'b0; cpu3 = 1'b0; we3 = 1'b0; addr3 = 32'b0; wd3 = 32'b0; ctl3 = 3'd0; sw3 = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n0 = 1'b1; rst_n3 = 1'b1;
    #1;
    chk("rst_din0", din0, 32'd0);
    chk("rst_rdy0", 32'(rdy0), 32'd0);
    chk("rst_led0", 32'(led0), 32'd0);
    chk("rst_err0", 32'(err0), 32'd0);
    chk("rst_din3", din3, 32'd0);
    chk("rst_rdy3", 32'(rdy3), 32'd0);
    chk("rst_led3", 32'(led3), 32'd0);

    // Cycle counter read straight out of reset, then on each following edge
    cpu0 = 1'b1; we0 = 1'b0; addr0 = 32'hF000_0008; ctl0 = 3'd0;
    #1;
    chk("cnt_0", din0, 32'd0);
    chk("rdy_comb", 32'(rdy0), 32'd1);
    for (int i = 1; i <= 3; i++) ld0("cnt_step", 32'hF000_0008, 3'd0, 32'(i));

    for (int i = 0; i < 64; i++) st0(32'(i * 4), 32'd0, 3'd0);

    st0(32'h10, 32'h1234_5678, 3'd0);
    ld0("lb_13", 32'h13, 3'd1, 32'h0000_0012);
    st0(32'h10, 32'h0000_0080, 3'd1);
    ld0("lb_10", 32'h10, 3'd1, 32'hFFFF_FF80);
    ld0("lbu_10", 32'h10, 3'd3, 32'h0000_0080);
    st0(32'h22, 32'h0000_BEEF, 3'd2);
    ld0("lw_20", 32'h20, 3'd0, 32'hBEEF_0000);
    ld0("lh_22", 32'h22, 3'd2, 32'hFFFF_BEEF);
    ld0("lhu_22", 32'h22, 3'd4, 32'h0000_BEEF);
    ld0("ctrl7_as_w", 32'h10, 3'd7, 32'h1234_5680);

    st0(32'hF000_0000, 32'h0000_00A5, 3'd2);
    ld0("led_rd", 32'hF000_0000, 3'd0, 32'h0000_00A5);
    chk("led_out", 32'(led0), 32'h0000_00A5);
    ld0("sw_rd", 32'hF000_0004, 3'd0, 32'h0000_C3C3);
    ld0("mmio_hole", 32'hF000_000C, 3'd0, 32'h0000_0000);

    req0(1'b1, 32'h21, 32'hCAFE_F00D, 3'd0, rd, rdy, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_sw_err", 32'(er), 32'd1);
    ld0("mis_sw_word", 32'h20, 3'd0, 32'hBEEF_0000);
`else
    chk("mis_sw_err", 32'(er), 32'd0);
    ld0("mis_sw_word", 32'h20, 3'd0, 32'hCAFE_F00D);
`endif
    req0(1'b0, 32'h23, 32'b0, 3'd2, rd, rdy, er);
    chk("mis_lh", rd, m_load(0, 32'h23, 3'd2));
    chk("mis_lh_err", 32'(er), 32'(m_mis(32'h23, 3'd2)));

    st0(32'h1010, 32'hA1A2_A3A4, 3'd0);
    ld0("alias", 32'h10, 3'd0, 32'hA1A2_A3A4);

    for (int i = 0; i < 80; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(0, 255)) | (32'($urandom_range(0, 1)) << 12);
      c = 3'($urandom_range(0, 7));
      d = $urandom;
      req0(w, a, d, c, rd, rdy, er);
      chk("rnd0_rdy", 32'(rdy), 32'd1);
      chk("rnd0_err", 32'(er), 32'(m_mis(a, c)));
      if (!w) chk("rnd0_load", rd, m_load(0, a, c));
    end
    @(negedge clk);
    cpu0 = 1'b0;

    // Three-wait-state instance
    for (int i = 0; i < 16; i++) req3(1'b1, 32'(32'h40 + i * 4), 32'd0, 3'd0, rd, er);
    req3(1'b1, 32'h40, 32'h1122_3344, 3'd0, rd, er);
    req3(1'b0, 32'h40, 32'b0, 3'd0, rd, er);
    chk("ws3_lw", rd, 32'h1122_3344);

    @(negedge clk);
    cpu3 = 1'b1; we3 = 1'b1; addr3 = 32'h40; wd3 = 32'h5566_7788; ctl3 = 3'd0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n3 = 1'b0; cpu3 = 1'b0;
    pulses = 0;
    #1;
    if (rdy3) pulses++;
    @(negedge clk);
    rst_n3 = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy3) pulses++;
    end
    chk("ws3_rst_no_pulse", 32'(pulses), 32'd0);
    chk("ws3_rst_din", din3, 32'd0);
    req3(1'b0, 32'h40, 32'b0, 3'd0, rd, er);
    chk("ws3_rst_ram_kept", rd, 32'h1122_3344);

    for (int i = 0; i < 12; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 32'($urandom_range(32'h40, 32'h7F));
      c = 3'($urandom_range(0, 7));
      d = $urandom;
      req3(w, a, d, c, rd, er);
      chk("rnd3_err", 32'(er), 32'(m_mis(a, c)));
      if (!w) chk("rnd3_load", rd, m_load(1, a, c));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
